// File: rtl/counter_mod_if.sv
// Control and status bundle for counter_mod: count/direction/load inputs, count value and flags.
// The master drives the controls, and the counter (the slave) returns Q, tc and ovf.
interface counter_mod_if #(
    parameter int unsigned WIDTH = 8
);
    logic             count;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             ovf;

    modport master (
        output count, up_down, load, load_value,
        input  Q, tc, ovf
    );

    modport slave (
        input  count, up_down, load, load_value,
        output Q, tc, ovf
    );
endinterface

// File: rtl/counter_mod.sv
// Parametrised up/down event counter with parallel load, wrap or saturate mode, a clock-enable
// prescaler, a one-cycle terminal-count pulse and a sticky overflow flag.
module counter_mod #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_VALUE = 255,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned PRESCALE  = 1
) (
    input logic          clock,
    input logic          clear,
    counter_mod_if.slave bus
);

    localparam int unsigned      PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VALUE);

    logic [WIDTH-1:0] q_r;
    logic             tc_r;
    logic             ovf_r;
    logic [PS_W-1:0]  presc;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   q_step;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   load_clamp;
    logic             at_top;
    logic             at_bot;
    logic             boundary;
    logic             unused_msbs;

    // Step arithmetic runs one bit wider so that MAX_VALUE = 2^WIDTH-1 wraps cleanly.
    always_comb begin
        q_ext    = {1'b0, q_r};
        at_top   = (q_ext >= MAX_EXT);
        at_bot   = (q_r == '0);
        boundary = bus.up_down ? at_top : at_bot;
        q_step   = q_ext;
        if (bus.up_down) begin
            if (at_top) q_step = SATURATE ? MAX_EXT : '0;
            else        q_step = q_ext + 1'b1;
        end else begin
            if (at_bot) q_step = SATURATE ? '0 : MAX_EXT;
            else        q_step = q_ext - 1'b1;
        end
        load_ext   = {1'b0, bus.load_value};
        load_clamp = (load_ext > MAX_EXT) ? MAX_EXT : load_ext;
    end

    assign unused_msbs = q_step[WIDTH] ^ load_clamp[WIDTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            q_r   <= '0;
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
            presc <= '0;
        end else if (bus.load) begin
            q_r   <= load_clamp[WIDTH-1:0];
            tc_r  <= 1'b0;
            presc <= '0;
        end else if (bus.count) begin
            if (presc == PS_LAST) begin
                presc <= '0;
                q_r   <= q_step[WIDTH-1:0];
                tc_r  <= boundary;
                if (boundary) ovf_r <= 1'b1;
            end else begin
                presc <= presc + 1'b1;
                tc_r  <= 1'b0;
            end
        end else begin
            tc_r <= 1'b0;
        end
    end

    assign bus.Q   = q_r;
    assign bus.tc  = tc_r;
    assign bus.ovf = ovf_r;

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: five parameterisations sharing clock and clear, exercised in turn.
module tb_counter_mod;

    logic clock;
    logic clear;
    int unsigned n_checks;
    int unsigned n_errors;

    counter_mod_if #(.WIDTH(8)) b1 ();
    counter_mod_if #(.WIDTH(4)) b2 ();
    counter_mod_if #(.WIDTH(4)) b3 ();
    counter_mod_if #(.WIDTH(8)) b4 ();
    counter_mod_if #(.WIDTH(8)) b5 ();

    counter_mod u1 (.clock(clock), .clear(clear), .bus(b1));
    counter_mod #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0), .PRESCALE(1))
        u2 (.clock(clock), .clear(clear), .bus(b2));
    counter_mod #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b1), .PRESCALE(1))
        u3 (.clock(clock), .clear(clear), .bus(b3));
    counter_mod #(.WIDTH(8), .MAX_VALUE(255), .SATURATE(1'b0), .PRESCALE(4))
        u4 (.clock(clock), .clear(clear), .bus(b4));
    counter_mod #(.WIDTH(8), .MAX_VALUE(100), .SATURATE(1'b0), .PRESCALE(1))
        u5 (.clock(clock), .clear(clear), .bus(b5));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned exp_q;
        int unsigned exp_tc;
        int unsigned exp_ovf;
        int unsigned q3 [5]   = '{8, 9, 9, 9, 9};
        int unsigned tc3 [5]  = '{0, 0, 1, 1, 1};
        int unsigned cnt4 [15] = '{1,1,1,1,1,1,1,1,1,1,0,0,0,1,1};
        int unsigned q4 [15]   = '{0,0,0,1,1,1,1,2,2,2,2,2,2,2,3};

        n_checks = 0;
        n_errors = 0;
        {b1.count, b1.up_down, b1.load, b1.load_value} = '0;
        {b2.count, b2.up_down, b2.load, b2.load_value} = '0;
        {b3.count, b3.up_down, b3.load, b3.load_value} = '0;
        {b4.count, b4.up_down, b4.load, b4.load_value} = '0;
        {b5.count, b5.up_down, b5.load, b5.load_value} = '0;
        b1.up_down = 1'b1;

        // Reset state
        clear = 1'b1;
        tick();
        check("rst_q", 32'(b1.Q), 0);
        check("rst_tc", 32'(b1.tc), 0);
        check("rst_ovf", 32'(b1.ovf), 0);
        check("rst_q_sat", 32'(b3.Q), 0);
        clear = 1'b0;

        // 1: default counter runs 0..255, wraps to 0,1 with tc on the wrap
        b1.count = 1'b1;
        exp_q = 0;
        exp_ovf = 0;
        for (int i = 0; i < 258; i++) begin
            tick();
            exp_tc = (exp_q == 255) ? 1 : 0;
            exp_q = (exp_q + 1) % 256;
            if (exp_tc == 1) exp_ovf = 1;
            check("t1_q", 32'(b1.Q), exp_q);
            check("t1_tc", 32'(b1.tc), exp_tc);
            check("t1_ovf", 32'(b1.ovf), exp_ovf);
        end
        check("t1_final_q", 32'(b1.Q), 2);
        b1.count = 1'b0;

        // 2: MAX_VALUE=9 wrap, counting down from 0
        b2.count = 1'b1;
        b2.up_down = 1'b0;
        exp_q = 0;
        exp_ovf = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_tc = (exp_q == 0) ? 1 : 0;
            exp_q = (exp_q == 0) ? 9 : exp_q - 1;
            if (exp_tc == 1) exp_ovf = 1;
            check("t2_q", 32'(b2.Q), exp_q);
            check("t2_tc", 32'(b2.tc), exp_tc);
            check("t2_ovf", 32'(b2.ovf), exp_ovf);
        end
        b2.count = 1'b0;

        // 3: saturate at 9 after loading 7, then one step down
        b3.load = 1'b1;
        b3.load_value = 4'd7;
        tick();
        check("t3_load_q", 32'(b3.Q), 7);
        b3.load = 1'b0;
        b3.count = 1'b1;
        b3.up_down = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_q", 32'(b3.Q), q3[i]);
            check("t3_tc", 32'(b3.tc), tc3[i]);
        end
        check("t3_ovf", 32'(b3.ovf), 1);
        b3.up_down = 1'b0;
        tick();
        check("t3_down_q", 32'(b3.Q), 8);
        check("t3_down_tc", 32'(b3.tc), 0);
        b3.count = 1'b0;
        b3.load = 1'b1;
        b3.load_value = 4'd15;
        tick();
        check("t3_clamp_q", 32'(b3.Q), 9);
        b3.load = 1'b0;

        // 4: PRESCALE=4 with a 3-cycle pause in count mid-period
        b4.up_down = 1'b1;
        for (int i = 0; i < 15; i++) begin
            b4.count = cnt4[i][0];
            tick();
            check("t4_q", 32'(b4.Q), q4[i]);
            check("t4_tc", 32'(b4.tc), 0);
        end
        b4.count = 1'b0;

        // 5: priority clear > load > count, and load clamps to MAX_VALUE
        b5.up_down = 1'b1;
        b5.load = 1'b1;
        b5.load_value = 8'd100;
        tick();
        check("t5_load_q", 32'(b5.Q), 100);
        b5.load = 1'b0;
        b5.count = 1'b1;
        tick();
        check("t5_wrap_q", 32'(b5.Q), 0);
        check("t5_wrap_tc", 32'(b5.tc), 1);
        check("t5_wrap_ovf", 32'(b5.ovf), 1);
        clear = 1'b1;
        b5.load = 1'b1;
        b5.load_value = 8'd5;
        tick();
        check("t5_clr_q", 32'(b5.Q), 0);
        check("t5_clr_tc", 32'(b5.tc), 0);
        check("t5_clr_ovf", 32'(b5.ovf), 0);
        clear = 1'b0;
        b5.load_value = 8'd200;
        tick();
        check("t5_ldcnt_q", 32'(b5.Q), 100);
        check("t5_ldcnt_tc", 32'(b5.tc), 0);
        b5.load = 1'b0;
        tick();
        check("t5_wrap2_q", 32'(b5.Q), 0);
        check("t5_wrap2_tc", 32'(b5.tc), 1);
        b5.load = 1'b1;
        b5.load_value = 8'd3;
        tick();
        check("t5_ld_q", 32'(b5.Q), 3);
        check("t5_ld_tc", 32'(b5.tc), 0);
        check("t5_ld_ovf", 32'(b5.ovf), 1);
        b5.load = 1'b0;
        b5.count = 1'b0;

        // 6: clear mid-burst drops ovf and partial prescale progress
        b4.load = 1'b1;
        b4.load_value = 8'd255;
        tick();
        check("t6_load_q", 32'(b4.Q), 255);
        b4.load = 1'b0;
        b4.count = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_pre_q", 32'(b4.Q), 255);
        end
        tick();
        check("t6_wrap_q", 32'(b4.Q), 0);
        check("t6_wrap_tc", 32'(b4.tc), 1);
        check("t6_wrap_ovf", 32'(b4.ovf), 1);
        tick();
        tick();
        check("t6_mid_tc", 32'(b4.tc), 0);
        check("t6_mid_ovf", 32'(b4.ovf), 1);
        clear = 1'b1;
        tick();
        check("t6_clr_q", 32'(b4.Q), 0);
        check("t6_clr_tc", 32'(b4.tc), 0);
        check("t6_clr_ovf", 32'(b4.ovf), 0);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_restart_q", 32'(b4.Q), 0);
        end
        tick();
        check("t6_step_q", 32'(b4.Q), 1);
        b4.count = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_mod.md
Name: counter_mod

Overview:
- Parametrised successor to the team's basic 8-bit synchronous counter.
- Programmable width and terminal value.
- Adds up/down direction, parallel load, wrap or saturate mode, a clock-enable prescaler, a terminal-count pulse and a sticky overflow flag.
- Used as a general event/timebase counter in the counter module library; single clock domain.

Parameters:
- WIDTH, 8, counter width in bits (1..32).
- MAX_VALUE, 255, terminal value; the count range is 0..MAX_VALUE; must be <= 2^WIDTH-1.
- SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries.
- PRESCALE, 1, number of enabled cycles per count step (1..65535); 1 = step every enabled cycle.

Ports:
- clock  input  1  rising-edge clock for all state.
- clear  input  1  synchronous, active-high reset; highest priority.
- count  input  1  count enable.
- up_down  input  1  direction: 1 = increment, 0 = decrement; sampled on each step.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value for load.
- Q  output  WIDTH  registered count value.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky overflow/underflow flag.

Behaviour:
- All state updates occur on the rising edge of clock. Outputs are registered, with no combinational path from inputs to outputs.
- Reset (clear=1): Q=0, tc=0, ovf=0, prescaler=0. Overrides load and count in the same cycle. Asserting clear mid-count discards any partial prescale progress.
- Priority per cycle: clear > load > count.
- Load (load=1, clear=0):
  - Q = min(load_value, MAX_VALUE).
  - Prescaler reset to 0; tc=0; ovf unchanged.
  - count is ignored in that cycle.
- Prescaler:
  - Internal counter of ceil(log2(PRESCALE)) bits, minimum 1 bit.
  - Advances only when count=1 and neither clear nor load is active.
  - A step occurs on a cycle where count=1 and prescaler==PRESCALE-1; the prescaler then returns to 0.
  - count=0 freezes the prescaler and does not reset it.
  - PRESCALE=1: a step occurs on every cycle with count=1.
- Step, up (up_down=1):
  - Q<MAX_VALUE: Q=Q+1.
  - Q==MAX_VALUE: Q=0 if SATURATE=0; Q holds if SATURATE=1.
- Step, down (up_down=0):
  - Q>0: Q=Q-1.
  - Q==0: Q=MAX_VALUE if SATURATE=0; Q holds if SATURATE=1.
- Boundary step: a step taken from Q==MAX_VALUE (up) or Q==0 (down).
  - tc=1 for exactly the one cycle after a boundary step; otherwise tc=0.
  - ovf set to 1 on a boundary step; cleared only by clear.
  - In SATURATE=1, tc pulses on every attempted step while held at the boundary.
- Step arithmetic uses WIDTH+1 bits internally. Q never exceeds MAX_VALUE, including when MAX_VALUE < 2^WIDTH-1.
- No step cycle (count=0, or prescaler not at terminal): Q holds, tc=0.
- Direction change takes effect on the next step with no lost or extra step. up_down is don't-care on non-step cycles.
- Defaults (WIDTH=8, MAX_VALUE=255, SATURATE=0, PRESCALE=1, up_down=1, load=0) reproduce the basic counter's Q behaviour exactly.

Test Plan:
1. Defaults: clear 1 cycle, count=1, up_down=1 for 258 cycles -> Q runs 0..255 then 0,1; tc=1 only on the cycle Q becomes 0 after 255; ovf=1 from then on.
2. MAX_VALUE=9, SATURATE=0, up_down=0 from Q=0, count=1 -> Q=9,8,...,0,9; tc pulses on each 0->9 transition; ovf set.
3. MAX_VALUE=9, SATURATE=1: load 7, count up 5 cycles -> Q=8,9,9,9,9; tc=1 on the 3rd, 4th and 5th steps; count down 1 -> Q=8.
4. PRESCALE=4, count=1 continuously -> Q increments every 4th cycle. Drop count for 3 cycles mid-period -> prescale progress kept, next step delayed exactly 3 cycles.
5. Priority: clear=1, load=1, load_value=5 in the same cycle -> Q=0, ovf=0. load=1, count=1, load_value=200 with MAX_VALUE=100 -> Q=100, tc=0.
6. Reset mid-operation: set ovf, then clear during a count burst -> next cycle Q=0, tc=0, ovf=0, prescaler restarts from 0.
